// File: rtl/conv_stream_pkg.sv
// Shared types for the convolution stream source: FSM state encoding and
// the width of the frame repeat counter.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int FRAME_W = 8;

endpackage

// File: rtl/conv_vec_source_if.sv
// Downstream valid/ready sample stream between the vector source and the
// first convolution layer.
interface conv_vec_source_if #(
    parameter int T = 8
);
    logic signed [T-1:0] m_data_out;
    logic                m_valid;
    logic                m_ready;

    modport master (output m_data_out, output m_valid, input m_ready);
    modport slave  (input m_data_out, input m_valid, output m_ready);
endinterface

// File: rtl/conv_vec_mem.sv
// N x T sample store: one write port, one registered read port.
module conv_vec_mem #(
    parameter int N  = 8,
    parameter int T  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [T-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [T-1:0] rd_data
);
    localparam logic [AW:0] N_LIM = (AW+1)'(N);

    logic signed [T-1:0] mem [N];

    // Addresses beyond the last word are dropped when N is not a power of two.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < N_LIM)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/conv_vec_source.sv
// Holds one N-word vector and streams it, repeated a given number of frames,
// onto a valid/ready interface with no bubbles.
module conv_vec_source
    import conv_stream_pkg::*;
#(
    parameter int N = 8,
    parameter int T = 8,
    localparam int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [T-1:0] wr_data,
    input  logic                start,
    input  logic [FRAME_W-1:0]  frames,
    output logic                busy,
    output logic                done,
    conv_vec_source_if.master   m
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    state_t               state_reg;
    logic [AW-1:0]        rd_addr_reg;
    logic [AW-1:0]        rd_addr_next;
    logic [FRAME_W-1:0]   frame_cnt_reg;
    logic [FRAME_W-1:0]   frames_reg;
    logic                 valid_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic signed [T-1:0]  rd_data;

    logic accept;
    logic hs;
    logic last_word;
    logic last_frame;

    assign accept     = (state_reg == S_IDLE) && start && !wr_en;
    assign hs         = (state_reg == S_STREAM) && m.m_ready;
    assign last_word  = (rd_addr_reg == LAST_ADDR);
    assign last_frame = (frame_cnt_reg == frames_reg - FRAME_W'(1));

    // The memory is addressed one step ahead so the next word is already
    // registered at its output when the current one is accepted.
    always_comb begin
        rd_addr_next = rd_addr_reg;
        if (accept) begin
            rd_addr_next = '0;
        end else if (hs) begin
            rd_addr_next = last_word ? '0 : rd_addr_reg + AW'(1);
        end
    end

    conv_vec_mem #(.N(N), .T(T), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && (state_reg == S_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_next),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            rd_addr_reg   <= '0;
            frame_cnt_reg <= '0;
            frames_reg    <= FRAME_W'(1);
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            rd_addr_reg <= rd_addr_next;
            done_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        frames_reg    <= (frames == '0) ? FRAME_W'(1) : frames;
                        frame_cnt_reg <= '0;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (hs && last_word) begin
                        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
                        if (last_frame) begin
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign m.m_valid    = valid_reg;
    assign m.m_data_out = rd_data;
    assign busy         = busy_reg;
    assign done         = done_reg;
endmodule

// File: tb/tb_conv_vec_source.sv
// Bench for conv_vec_source: a queue model of the expected stream checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_conv_vec_source;
    localparam int N = 8;
    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic              start;
    logic [7:0]        frames;
    logic              busy;
    logic              done;

    conv_vec_source_if #(.T(T)) sif ();

    conv_vec_source #(.N(N), .T(T)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .frames  (frames),
        .busy    (busy),
        .done    (done),
        .m       (sif.master)
    );

    // Second instance with a non-power-of-two depth for out-of-range writes.
    logic              b_wr_en;
    logic [2:0]        b_wr_addr;
    logic signed [7:0] b_wr_data;
    logic              b_start;
    logic [7:0]        b_frames;
    logic              b_busy;
    logic              b_done;

    conv_vec_source_if #(.T(8)) sif6 ();

    conv_vec_source #(.N(6), .T(8)) dut6 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (b_wr_en),
        .wr_addr (b_wr_addr),
        .wr_data (b_wr_data),
        .start   (b_start),
        .frames  (b_frames),
        .busy    (b_busy),
        .done    (b_done),
        .m       (sif6.master)
    );

    logic signed [7:0] vec [8] = '{8'sd3, -8'sd1, 8'sd4, -8'sd1, 8'sd5, -8'sd9, 8'sd2, 8'sd6};

    logic signed [7:0] mem_model [N];
    logic signed [7:0] exp_q [$];
    logic signed [7:0] run_log [$];
    bit                exp_done;
    int                hs_run;
    int                checks;
    int                failures;
    bit                rand_ready;
    bit                prev_valid;
    bit                prev_ready;
    logic signed [7:0] prev_data;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic bit model_idle();
        return (exp_q.size() == 0) && !exp_done;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit popped;
        if (reset !== 1'b0) begin
            prev_valid = 1'b0;
        end else begin
            popped = 1'b0;
            check("busy", longint'(busy), longint'(exp_q.size() > 0 || exp_done));
            check("done", longint'(done), longint'(exp_done));
            check("m_valid", longint'(sif.m_valid), longint'(exp_q.size() > 0));
            if (sif.m_valid && exp_q.size() > 0) begin
                check("data", sif.m_data_out, exp_q[0]);
                if (prev_valid && !prev_ready)
                    check("stall_hold", sif.m_data_out, prev_data);
                if (sif.m_ready) begin
                    $display("hs %0d data=%0d", hs_run, sif.m_data_out);
                    run_log.push_back(sif.m_data_out);
                    void'(exp_q.pop_front());
                    hs_run++;
                    popped = (exp_q.size() == 0);
                end
            end
            exp_done   = popped;
            prev_valid = sif.m_valid;
            prev_ready = sif.m_ready;
            prev_data  = sif.m_data_out;
        end
    end

    // Downstream ready: held high or toggled randomly.
    initial begin
        sif.m_ready  = 1'b1;
        sif6.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // One input cycle, called at #1 after a rising edge.
    task automatic cyc(input bit st, input bit we, input int addr, input int data);
        bit idle;
        int f;
        idle    = model_idle();
        start   = st;
        wr_en   = we;
        wr_addr = 3'(addr);
        wr_data = 8'(data);
        if (idle && we && addr < N) mem_model[addr] = 8'(data);
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        if (idle && st && !we) begin
            f = (frames == 0) ? 1 : int'(frames);
            hs_run = 0;
            run_log.delete();
            for (int k = 0; k < f; k++)
                for (int i = 0; i < N; i++)
                    exp_q.push_back(mem_model[i]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (model_idle()) return;
            @(posedge clk);
            #1;
        end
        check("idle_timeout", exp_q.size(), 0);
        exp_q.delete();
        exp_done = 1'b0;
    endtask

    task automatic run(input int nframes);
        frames = 8'(nframes);
        cyc(1'b1, 1'b0, 0, 0);
        wait_idle();
        repeat (2) cyc(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt6;
        logic signed [7:0] got6 [$];
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frames = 8'd1; rand_ready = 1'b0; exp_done = 1'b0; hs_run = 0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_frames = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 0, 0);

        // Load vector, single frame
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, i, int'(vec[i]));
        run(1);
        check("f1_count", hs_run, 8);
        check("f1_first", run_log[0], 3);
        check("f1_last", run_log[7], 6);

        // Three frames, and zero treated as one
        run(3);
        check("f3_count", hs_run, 24);
        check("f3_wrap", run_log[8], 3);
        check("f3_end", run_log[23], 6);
        run(0);
        check("f0_count", hs_run, 8);

        // Random stalls
        rand_ready = 1'b1;
        run(2);
        rand_ready = 1'b0;
        check("rand_count", hs_run, 16);
        for (int i = 0; i < 16; i++) check("rand_seq", run_log[i], vec[i % 8]);

        // Write and start while streaming are ignored
        frames = 8'd1;
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 2, 77);
        cyc(1'b1, 1'b0, 0, 0);
        wait_idle();
        check("busy_count", hs_run, 8);
        check("busy_addr2", run_log[2], 4);
        repeat (2) cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 2, 77);
        run(1);
        check("rerun_addr2", run_log[2], 77);

        // Start together with a write: write lands, no stream
        cyc(1'b1, 1'b1, 3, 55);
        repeat (3) cyc(1'b0, 1'b0, 0, 0);
        run(1);
        check("sw_addr3", run_log[3], 55);

        // Reset mid-stream after the fifth handshake
        frames = 8'd2;
        cyc(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 100 && hs_run < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_at_hs", hs_run, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_done = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 0, 0);
        run(1);
        check("post_rst_count", hs_run, 8);
        check("post_rst_w0", run_log[0], 3);
        check("post_rst_w2", run_log[2], 77);
        check("post_rst_w3", run_log[3], 55);

        // N=6 instance: addresses 6 and 7 are ignored
        for (int i = 0; i < 8; i++) begin
            b_wr_en = 1'b1;
            b_wr_addr = 3'(i);
            b_wr_data = (i < 6) ? 8'(10 + i) : 8'sd99;
            @(posedge clk);
            #1;
        end
        b_wr_en = 1'b0;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        cnt6 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sif6.m_valid && sif6.m_ready) begin
                $display("n6 hs %0d data=%0d", cnt6, sif6.m_data_out);
                got6.push_back(sif6.m_data_out);
                cnt6++;
            end
            if (b_done) break;
        end
        check("n6_done", longint'(b_done), 1);
        check("n6_count", cnt6, 6);
        for (int i = 0; i < 6 && i < got6.size(); i++) check("n6_data", got6[i], 10 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_vec_source.md
# conv_vec_source

Stream transmitter that feeds input vectors into the convolution chain (`layerX` / `multi_*` modules). It holds one N-word vector of signed T-bit samples, loaded through a simple write port. On `start` it drives the vector, repeated `frames` times, onto the downstream `s_data_in`/`s_valid`/`s_ready` interface of the first layer, with no bubbles. It is the producing end of the same valid/ready stream the layers consume, and it is used both on chip and as the bench stimulus source.

## Interface
Parameters:
- `N`, 8: words per vector; power of two not required, N ≥ 2.
- `T`, 8: sample width in bits, signed.

Ports:
- `clk`, in, 1: clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: write strobe into the vector memory.
- `wr_addr`, in, $clog2(N): write address; values ≥ N are ignored.
- `wr_data`, in, T: signed sample to write.
- `start`, in, 1: begin streaming; sampled only in IDLE.
- `frames`, in, 8: repeat count, latched on an accepted `start`; 0 is treated as 1.
- `m_data_out`, out, T: sample presented downstream.
- `m_valid`, out, 1: `m_data_out` is valid.
- `m_ready`, in, 1: downstream accepts; a handshake is `m_valid && m_ready` at a rising edge.
- `busy`, out, 1: high from the accepted `start` through the `done` cycle.
- `done`, out, 1: one-cycle pulse after the final handshake.

## Operation
- States: S_IDLE, S_STREAM, S_DONE.
- S_IDLE:
  - `wr_en` writes `mem[wr_addr] <= wr_data`.
  - `start && !wr_en` is accepted: latch `frames` (0→1), clear rd_addr and frame_cnt, go to S_STREAM.
  - `start && wr_en` in the same cycle: the write commits and the start is ignored.
- S_STREAM:
  - `m_valid` = 1 and `m_data_out` = mem[rd_addr].
  - On handshake: rd_addr increments. At N-1 it wraps to 0 and frame_cnt increments.
  - On the handshake of word N-1 of the last frame, go to S_DONE.
  - With no handshake, rd_addr and `m_data_out` hold stable; `m_data_out` must not change while `m_valid` is high and `m_ready` is low.
- S_DONE: `m_valid` = 0, `done` = 1, `busy` = 1 for exactly one cycle, then S_IDLE.
- `wr_en` is ignored outside S_IDLE; the memory is never corrupted mid-stream.
- `start` is ignored outside S_IDLE.
- The memory read is synchronous. The read address fed to memory is next_rd_addr (rd_addr+1 on handshake, wrapped; else rd_addr; 0 on accepted start), so data is present the cycle it is needed.

## Timing
- Reset values: `m_valid` 0, `done` 0, `busy` 0, state S_IDLE, rd_addr 0, frame_cnt 0, `m_data_out` undefined until the first stream. Memory contents are not reset and survive reset.
- Reset mid-stream: `m_valid` and `busy` are 0 the cycle after reset is sampled. No `done` pulse.
- Latency: `start` sampled at edge k gives `m_valid` = 1 with mem[0] in cycle k+1.
- Throughput: 1 word/cycle with `m_ready` held high; no bubbles at vector or frame wrap.
- Total handshakes per run: N × max(frames,1).
- `done` is high in the cycle after the final handshake. `start` is first re-accepted at the edge after `done`.
- `m_valid` never drops without a handshake on the current word (no retraction).
- A write in the last IDLE cycle before start (edge k-1) is visible in the stream.

## Structure
- Package `conv_stream_pkg` holds the `state_t` enum and the localparam for the repeat counter width (8).
- One sub-module, `conv_vec_mem`: an N×T register array with one write port and one synchronous read port (`clk`, `wr_en`, `wr_addr`, `wr_data`, `rd_addr`, `rd_data`). The rest is the FSM plus counters in `conv_vec_source`.

## Test plan
- Load mem = {3,-1,4,-1,5,-9,2,6}. Start with frames=1 and `m_ready`=1 → exactly 8 handshakes, values in order, `m_valid` rises one cycle after start, `done` one cycle after the 8th handshake.
- Same load, frames=3, `m_ready`=1 → 24 consecutive handshakes, no gap at the wraps (6→3). frames=0 → 8 handshakes.
- Random `m_ready` (50%) → data stable while stalled, sequence identical to the no-stall run, no drop or duplicate.
- `wr_en` to addr 2 (value 77) mid-stream and `start` while busy → stream unaffected (4 at addr 2), no restart. After done, a rerun shows 77.
- `start` and `wr_en` in the same cycle in IDLE → no stream starts, write committed. Write to `wr_addr` ≥ N → ignored.
- Reset at handshake 5 of frames=2 → `m_valid`/`busy` 0 next cycle, no `done`. A new start streams from word 0 with the memory intact.
